// File: rtl/arith_sched_pkg.sv
// Shared widths, mode codes, operand field layout and buffer state encoding
// for the arith_sched arbiter and its kernel datapath.
package arith_sched_pkg;

   localparam int NUM_REQ  = 2;
   localparam int OPND_W   = 4;
   localparam int OPND_BUS = 20;
   localparam int RES_W    = 8;
   localparam int MODE_W   = 2;
   localparam int NUM_MODE = 4;
   localparam int CNT_W    = 16;

   localparam int OFS_A = 0;
   localparam int OFS_B = 4;
   localparam int OFS_C = 8;
   localparam int OFS_D = 12;
   localparam int OFS_E = 16;

   localparam logic [MODE_W-1:0] MODE_M1 = 2'b00;
   localparam logic [MODE_W-1:0] MODE_M4 = 2'b01;
   localparam logic [MODE_W-1:0] MODE_M2 = 2'b10;
   localparam logic [MODE_W-1:0] MODE_M3 = 2'b11;

   localparam logic [OPND_W-1:0] M3_XOR_K = 4'hA;

   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_e;

   typedef struct packed {
      logic [OPND_BUS-1:0] opnd;
      logic [MODE_W-1:0]   mode;
   } req_t;

   function automatic logic [OPND_W-1:0] opnd_fld(input logic [OPND_BUS-1:0] o, input int ofs);
      return o[ofs +: OPND_W];
   endfunction

endpackage

// File: rtl/arith_sched_core.sv
// Combinational kernel datapath: four 8-bit modulo-256 kernels on
// zero-extended 4-bit operands, selected by mode.
module arith_sched_core
   import arith_sched_pkg::*;
(
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   input  logic [OPND_W-1:0] c,
   input  logic [OPND_W-1:0] d,
   input  logic [OPND_W-1:0] e,
   input  logic [MODE_W-1:0] mode,
   output logic [RES_W-1:0]  res
);

   logic [RES_W-1:0] za, zb, zc, zd, ze, zk;
   logic [RES_W-1:0] m1, m2, m3, m4;

   assign za = {4'h0, a};
   assign zb = {4'h0, b};
   assign zc = {4'h0, c};
   assign zd = {4'h0, d};
   assign ze = {4'h0, e};
   assign zk = {4'h0, M3_XOR_K};

   // all products are kept to 8 bits, giving the modulo-256 wrap
   assign m1 = (za + zb) * (zc + zd);
   assign m2 = (za * zc) + (zb * zd);
   assign m3 = ((za ^ zb) + zd) * (ze ^ zk);
   assign m4 = (m1 + m2) ^ (m3 >> 1);

   always_comb begin
      res = m1;
      case (mode)
         MODE_M1: res = m1;
         MODE_M4: res = m4;
         MODE_M2: res = m2;
         MODE_M3: res = m3;
         default: res = m1;
      endcase
   end

endmodule

// File: rtl/arith_sched.sv
// Round-robin arbiter feeding a shared kernel datapath into a one-entry
// response buffer. ARITH_SCHED_STATS_EN adds per-mode completion counters.
module arith_sched
   import arith_sched_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [OPND_BUS-1:0]       req0_opnd,
   input  logic [OPND_BUS-1:0]       req1_opnd,
   input  logic [MODE_W-1:0]         req0_mode,
   input  logic [MODE_W-1:0]         req1_mode,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [RES_W-1:0]          rsp_data,
   output logic                      rsp_id,
   output logic [NUM_MODE*CNT_W-1:0] stat_cnt
);

   buf_state_e          state, state_nxt;
   logic                ptr;
   logic [NUM_REQ-1:0]  gnt;
   logic                can_accept, accept, win;
   req_t [NUM_REQ-1:0]  req;
   req_t                sel;
   logic [RES_W-1:0]    res;

   assign req[0] = '{opnd: req0_opnd, mode: req0_mode};
   assign req[1] = '{opnd: req1_opnd, mode: req1_mode};

   // with both valid the pointer decides; a lone requester always wins
   assign gnt[0] = req_valid[0] & (~req_valid[1] | ~ptr);
   assign gnt[1] = req_valid[1] & (~req_valid[0] |  ptr);

   assign can_accept = rst_n & ((state == BUF_EMPTY) | rsp_ready);
   assign req_ready  = gnt & {NUM_REQ{can_accept}};
   assign accept     = |req_ready;
   assign win        = gnt[1];
   assign sel        = req[win];

   arith_sched_core u_core (
      .a    (opnd_fld(sel.opnd, OFS_A)),
      .b    (opnd_fld(sel.opnd, OFS_B)),
      .c    (opnd_fld(sel.opnd, OFS_C)),
      .d    (opnd_fld(sel.opnd, OFS_D)),
      .e    (opnd_fld(sel.opnd, OFS_E)),
      .mode (sel.mode),
      .res  (res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= BUF_EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (accept)                              state_nxt = BUF_FULL;
      else if (state == BUF_FULL && rsp_ready) state_nxt = BUF_EMPTY;
   end

   assign rsp_valid = (state == BUF_FULL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data <= '0;
         rsp_id   <= 1'b0;
         ptr      <= 1'b0;
      end else if (accept) begin
         rsp_data <= res;
         rsp_id   <= win;
         ptr      <= ~win;
      end
   end

`ifdef ARITH_SCHED_STATS_EN
   logic [MODE_W-1:0]                buf_mode;
   logic [NUM_MODE-1:0][CNT_W-1:0]   cnt;
   logic                             done;

   assign done = rsp_valid & rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      buf_mode <= '0;
      else if (accept) buf_mode <= sel.mode;
   end

   for (genvar k = 0; k < NUM_MODE; k++) begin : g_cnt
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            cnt[k] <= '0;
         else if (done && buf_mode == MODE_W'(k) && cnt[k] != {CNT_W{1'b1}})
            cnt[k] <= cnt[k] + 1'b1;
      end
   end

   assign stat_cnt = cnt;
`else
   assign stat_cnt = '0;
`endif

endmodule

// File: tb/tb_arith_sched.sv
// Scoreboard bench for arith_sched: stimulus pushes hand-computed responses,
// a negedge monitor pops and compares on each completed response handshake.
module tb_arith_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [19:0] req0_opnd, req1_opnd;
   logic [1:0]  req0_mode, req1_mode;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [7:0]  rsp_data;
   logic        rsp_id;
   logic [63:0] stat_cnt;

   int checks = 0;
   int errors = 0;
   logic [8:0] sb[$];

   arith_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req0_opnd (req0_opnd),
      .req1_opnd (req1_opnd),
      .req0_mode (req0_mode),
      .req1_mode (req1_mode),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .stat_cnt  (stat_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id %0d data %0h expected none", rsp_id, rsp_data);
         end else begin
            logic [8:0] e;
            e = sb.pop_front();
            chk("rsp_id", 64'(rsp_id), 64'(e[8]));
            chk("rsp_data", 64'(rsp_data), 64'(e[7:0]));
         end
      end
   end

   // present a request, wait (bounded) for its accept, record expected result
   task automatic send(input int id, input logic [19:0] o, input logic [1:0] m, input logic [7:0] exp);
      int n;
      if (id == 0) begin req0_opnd = o; req0_mode = m; end
      else         begin req1_opnd = o; req1_mode = m; end
      req_valid[id] = 1'b1;
      n = 0;
      @(negedge clk);
      while (req_ready[id] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: requester %0d got no req_ready expected accept", id);
      end else begin
         sb.push_back({id[0], exp});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = 2'b00;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // both valid: expected one-hot grant sequence 0,1,0,1,...
   localparam logic [7:0] FAIR_DATA [2] = '{8'h19, 8'h84};

   initial begin
      rst_n = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      req0_opnd = 20'h54123; req0_mode = 2'b00;
      req1_opnd = 20'hFFFFF; req1_mode = 2'b00;
      #1;
      chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("reset_rsp_data", 64'(rsp_data), 64'd0);
      chk("reset_rsp_id", 64'(rsp_id), 64'd0);
      chk("reset_req_ready", 64'(req_ready), 64'd0);
      chk("reset_stat_cnt", stat_cnt, 64'd0);
      idle();
      cyc(2);
      rst_n = 1'b1;
      cyc(1);

      // kernels, requester 0
      send(0, 20'h54123, 2'b00, 8'h19);
      send(0, 20'h54123, 2'b10, 8'h0B);
      send(0, 20'h54123, 2'b11, 8'h4B);
      send(0, 20'h54123, 2'b01, 8'h01);
      idle();
      // wrap-around via requester 1 (leaves pointer at 0)
      send(1, 20'hFFFFF, 2'b00, 8'h84);
      send(1, 20'hFFFFF, 2'b11, 8'h4B);
      idle();
      cyc(2);

      // fairness
      req0_opnd = 20'h54123; req0_mode = 2'b00;
      req1_opnd = 20'hFFFFF; req1_mode = 2'b00;
      req_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("fair_req_ready", 64'(req_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
         sb.push_back({k[0], FAIR_DATA[k % 2]});
         @(posedge clk);
         #1;
      end
      idle();
      cyc(2);

      // backpressure
      rsp_ready = 1'b0;
      send(0, 20'h54123, 2'b00, 8'h19);
      idle();
      req1_opnd = 20'h54123; req1_mode = 2'b10;
      req_valid = 2'b10;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_rsp_data", 64'(rsp_data), 64'h19);
         chk("bp_rsp_id", 64'(rsp_id), 64'd0);
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", 64'(req_ready), 64'd2);
      sb.push_back({1'b1, 8'h0B});
      @(posedge clk);
      #1;
      idle();
      @(negedge clk);
      chk("bp_no_bubble", 64'(rsp_valid), 64'd1);
      cyc(2);

      // reset with a full buffer
      rsp_ready = 1'b0;
      send(0, 20'h54123, 2'b01, 8'h01);
      idle();
      req_valid = 2'b11;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("midrst_rsp_data", 64'(rsp_data), 64'd0);
      chk("midrst_req_ready", 64'(req_ready), 64'd0);
      sb.delete();
      cyc(2);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      req0_opnd = 20'h54123; req0_mode = 2'b00;
      req1_opnd = 20'hFFFFF; req1_mode = 2'b11;
      @(negedge clk);
      chk("postrst_grant0", 64'(req_ready), 64'd1);
      sb.push_back({1'b0, 8'h19});
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("postrst_grant1", 64'(req_ready), 64'd2);
      sb.push_back({1'b1, 8'h4B});
      @(posedge clk);
      #1;
      idle();
      cyc(3);

`ifdef ARITH_SCHED_STATS_EN
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      cyc(1);
      for (int k = 0; k < 3; k++) send(0, 20'h54123, 2'b10, 8'h0B);
      idle();
      cyc(3);
      chk("stat_m10_three", stat_cnt, {16'h0, 16'd3, 16'h0, 16'h0});
      for (int k = 0; k < 65536; k++) send(0, 20'h54123, 2'b00, 8'h19);
      idle();
      cyc(3);
      chk("stat_sat_ffff", stat_cnt, {16'h0, 16'd3, 16'h0, 16'hFFFF});
`else
      chk("stat_zero_nomacro", stat_cnt, 64'd0);
`endif

      for (int n = 0; n < 50 && sb.size() != 0; n++) cyc(1);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

`ifndef ARITH_SCHED_STATS_EN
   always @(negedge clk) begin
      if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1)
         chk("stat_zero_run", stat_cnt, 64'd0);
   end
`endif

endmodule

// File: doc/arith_sched.md
# arith_sched

- Arbitrates two requesters onto a single shared 4-bit-operand arithmetic datapath (four selectable kernels, 8-bit result).
- Registers the result into a one-entry response buffer and returns it with the winning requester's ID over a valid/ready handshake.
- Sits between the issuing units and the shared arithmetic resource; sustains one operation per cycle when the response side does not stall.

## Interface
- No parameters; all widths fixed by `arith_sched_pkg`.
- `clk` — in, 1 — single clock, rising edge.
- `rst_n` — in, 1 — reset, asynchronous, active-low.
- `req_valid` — in, 2 — per-requester request valid; bit i is requester i.
- `req_ready` — out, 2 — per-requester accept; at most one bit high per cycle.
- `req0_opnd`, `req1_opnd` — in, 20 — operand fields:
  - a = [3:0], b = [7:4], c = [11:8], d = [15:12], e = [19:16].
- `req0_mode`, `req1_mode` — in, 2 — kernel select.
- `rsp_valid` — out, 1 — response buffer holds a result.
- `rsp_ready` — in, 1 — consumer accepts the response.
- `rsp_data` — out, 8 — result.
- `rsp_id` — out, 1 — requester that issued the result.
- `stat_cnt` — out, 64 — per-mode completion counters; mode k occupies [16k+15:16k].

## Operation
- **Kernels.** All arithmetic is 8-bit, modulo 256. Operands are zero-extended before use.
  - M1 = (a+b)·(c+d)
  - M2 = a·c + b·d
  - M3 = ((a^b)+d)·(e^4'hA)
  - M4 = (M1+M2) ^ (M3>>1), where the shift is a logical shift of the 8-bit M3.
- **Mode map.** 00→M1, 01→M4, 10→M2, 11→M3.
- **Buffer state machine.** States EMPTY and FULL.
  - `can_accept` = EMPTY, or (FULL & `rsp_ready`).
  - A request is accepted when `can_accept` holds and a requester is granted. The result and ID are loaded into the buffer and the state becomes (or stays) FULL.
  - FULL & `rsp_ready` with no new acceptance → EMPTY.
- **Arbitration.** Round-robin with a 1-bit priority pointer (0 after reset).
  - One requester valid: that requester is granted.
  - Both valid: the requester equal to the pointer is granted.
  - After a grant to requester i, the pointer becomes 1−i.
  - The pointer updates only on an actual acceptance.
- **Ready.** `req_ready[i]` = grant[i] & `can_accept`. It is combinational from `req_valid` and `rsp_ready`.
- **Requester obligations.** Hold valid, operands and mode stable until accepted. Deasserting valid before acceptance is legal and simply withdraws the request.
- **Simultaneous drain and accept.** Handled in the same cycle; no bubble.
- **Reset (including mid-operation).**
  - `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, pointer=0, `stat_cnt`=0.
  - `req_ready`=0 while `rst_n` is low.
  - A buffered, undelivered result is discarded.

## Timing
- Latency: request accepted at edge N → `rsp_valid`=1 with data from cycle N+1.
- Throughput: 1 op/cycle while `rsp_ready`=1.
- Under sustained dual requests, grants alternate 0,1,0,1…
- With `rsp_ready`=0 and the buffer FULL:
  - `req_ready`=00.
  - `rsp_data` and `rsp_id` are held stable.
- Outputs `rsp_*` come directly from flops. `req_ready` is combinational.

## Configuration
- Macro: `ARITH_SCHED_STATS_EN`.
- **Defined.**
  - Four 16-bit counters, one per mode code.
  - The counter for a mode increments when a response of that mode completes its handshake (`rsp_valid` & `rsp_ready`). The buffer therefore also stores the mode.
  - Counters saturate at 16'hFFFF.
- **Undefined.**
  - No counters and no stored mode.
  - `stat_cnt` is tied to 64'h0 and the port remains present.

## Structure
- **`arith_sched_pkg`**
  - Mode constants: MODE_M1=2'b00, MODE_M4=2'b01, MODE_M2=2'b10, MODE_M3=2'b11.
  - Operand field offsets and widths.
  - Buffer state encoding: EMPTY/FULL.
  - Constant 4'hA used by M3.
- **Sub-module `arith_sched_core`**
  - Purely combinational kernel datapath: a–e and mode in, 8-bit result out.
  - Instantiated once on the muxed winner operands.
- The top level holds the arbiter, buffer FSM, pointer and counters.

## Test plan
- **Kernels.** Requester 0 alone, operand fields a=3, b=2, c=1, d=4, e=5 (`req0_opnd`=20'h54123), modes 00/10/11/01 → `rsp_data` 8'h19 / 8'h0B / 8'h4B / 8'h01, `rsp_id`=0, each one cycle after its accept.
- **Wrap-around.** All operands 4'hF: mode 00 → 8'h84 (900 mod 256); mode 11 → 8'h4B.
- **Fairness.** Both requesters valid continuously for 6 accepts with `rsp_ready`=1 → `rsp_id` sequence 0,1,0,1,0,1; `req_ready` is never 2'b11.
- **Backpressure.** Hold `rsp_ready`=0 for 3 cycles with a FULL buffer → `req_ready`=00 and `rsp_data` stable. Release → drain and a new accept in the same cycle, with no idle cycle on `rsp_valid`.
- **Reset mid-operation.** Assert `rst_n` low with the buffer FULL → `rsp_valid` drops to 0 immediately. After release, both requesters valid → requester 0 is granted first.
- **Stats** (with `ARITH_SCHED_STATS_EN`).
  - Three mode-10 responses completed → `stat_cnt`[47:32]=3, all other fields 0.
  - A counter forced to 16'hFFFF stays at 16'hFFFF on a further completion.
  - Without the macro, `stat_cnt`=0 throughout.
